// File: rtl/inversion_pkg.sv
// Shared types and constants for the inversion mutation engine and its LFSR.
package inversion_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PICK,
    ST_SWAP,
    ST_DONE
  } state_e;

  typedef logic [7:0] idx_t;

  localparam logic [15:0] LFSR_TAPS    = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

  // Maps an 8-bit random byte onto 0..n-1 without a divider.
  function automatic idx_t scale_idx(input logic [7:0] r, input idx_t n);
    return idx_t'((16'(r) * 16'(n)) >> 8);
  endfunction

endpackage

// File: rtl/ga_lfsr.sv
// 16-bit right-shifting Galois LFSR with seed load; a zero seed is replaced by DEFAULT_SEED.
module ga_lfsr
  import inversion_pkg::*;
#(
  parameter logic [15:0] SEED = DEFAULT_SEED
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic [15:0] seed_i,
  output logic [15:0] state_o
);

  logic [15:0] lfsr_q, lfsr_d;

  always_comb begin
    if (load_i) begin
      lfsr_d = (seed_i == 16'h0000) ? DEFAULT_SEED : seed_i;
    end else begin
      lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign state_o = lfsr_q;

endmodule

// File: rtl/inversion_unit.sv
// Inversion mutation engine: reverses the genes between two indices, one swap per cycle.
// Define INVERSION_FORCE_EN to add force_en/force_lo/force_hi for overriding the segment.
//
// state | meaning
// IDLE  | parent_ready high, waiting for a parent
// PICK  | derive, clamp and latch the segment bounds
// SWAP  | exchange genes lo/hi, pointers step inward
// DONE  | mutant_valid high until mutant_ready
module inversion_unit
  import inversion_pkg::*;
#(
  parameter int          N_GENES  = 15,
  parameter int          GENE_W   = 10,
  parameter int          MAX_SPAN = 15,
  parameter logic [15:0] SEED     = DEFAULT_SEED
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      seed_we,
  input  logic [15:0]               prg_seed,
`ifdef INVERSION_FORCE_EN
  input  logic                      force_en,
  input  logic [7:0]                force_lo,
  input  logic [7:0]                force_hi,
`endif
  input  logic                      parent_valid,
  output logic                      parent_ready,
  input  logic [N_GENES*GENE_W-1:0] parent,
  output logic                      mutant_valid,
  input  logic                      mutant_ready,
  output logic [N_GENES*GENE_W-1:0] mutant,
  output logic [7:0]                seg_lo,
  output logic [7:0]                seg_hi
);

  localparam int   CW      = N_GENES * GENE_W;
  localparam idx_t N_IDX   = idx_t'(N_GENES);
  localparam idx_t SPAN_M1 = idx_t'(MAX_SPAN - 1);

  state_e            state_q, state_d;
  logic [CW-1:0]     work_q, work_d;
  idx_t              lo_q, lo_d, hi_q, hi_d;
  idx_t              seg_lo_q, seg_lo_d, seg_hi_q, seg_hi_d;
  logic [15:0]       lfsr;
  idx_t              a, b, pick_lo, pick_hi;
  logic [GENE_W-1:0] gene_lo, gene_hi;

  ga_lfsr #(.SEED(SEED)) u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .load_i  (seed_we),
    .seed_i  (prg_seed),
    .state_o (lfsr)
  );

`ifdef INVERSION_FORCE_EN
  localparam idx_t N_MAX = idx_t'(N_GENES - 1);

  logic force_q, force_d;
  idx_t flo_q, flo_d, fhi_q, fhi_d;

  function automatic idx_t clamp_idx(input idx_t i);
    return (i >= N_IDX) ? N_MAX : i;
  endfunction
`endif

  always_comb begin
`ifdef INVERSION_FORCE_EN
    if (force_q) begin
      a = clamp_idx(flo_q);
      b = clamp_idx(fhi_q);
    end else begin
      a = scale_idx(lfsr[15:8], N_IDX);
      b = scale_idx(lfsr[7:0], N_IDX);
    end
`else
    a = scale_idx(lfsr[15:8], N_IDX);
    b = scale_idx(lfsr[7:0], N_IDX);
`endif
    pick_lo = (a < b) ? a : b;
    pick_hi = (a < b) ? b : a;
    if ((pick_hi - pick_lo) > SPAN_M1) begin
      pick_hi = pick_lo + SPAN_M1;
    end
  end

  assign gene_lo = work_q[int'(lo_q)*GENE_W +: GENE_W];
  assign gene_hi = work_q[int'(hi_q)*GENE_W +: GENE_W];

  always_comb begin
    state_d      = state_q;
    work_d       = work_q;
    lo_d         = lo_q;
    hi_d         = hi_q;
    seg_lo_d     = seg_lo_q;
    seg_hi_d     = seg_hi_q;
    parent_ready = 1'b0;
    mutant_valid = 1'b0;
`ifdef INVERSION_FORCE_EN
    force_d      = force_q;
    flo_d        = flo_q;
    fhi_d        = fhi_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        parent_ready = 1'b1;
        if (parent_valid) begin
          work_d  = parent;
          state_d = ST_PICK;
`ifdef INVERSION_FORCE_EN
          force_d = force_en;
          flo_d   = force_lo;
          fhi_d   = force_hi;
`endif
        end
      end
      ST_PICK: begin
        seg_lo_d = pick_lo;
        seg_hi_d = pick_hi;
        lo_d     = pick_lo;
        hi_d     = pick_hi;
        state_d  = (pick_lo < pick_hi) ? ST_SWAP : ST_DONE;
      end
      ST_SWAP: begin
        work_d[int'(lo_q)*GENE_W +: GENE_W] = gene_hi;
        work_d[int'(hi_q)*GENE_W +: GENE_W] = gene_lo;
        lo_d = lo_q + 8'd1;
        hi_d = hi_q - 8'd1;
        if (lo_d >= hi_d) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        mutant_valid = 1'b1;
        if (mutant_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      work_q   <= '0;
      lo_q     <= '0;
      hi_q     <= '0;
      seg_lo_q <= '0;
      seg_hi_q <= '0;
`ifdef INVERSION_FORCE_EN
      force_q  <= 1'b0;
      flo_q    <= '0;
      fhi_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      work_q   <= work_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
      seg_lo_q <= seg_lo_d;
      seg_hi_q <= seg_hi_d;
`ifdef INVERSION_FORCE_EN
      force_q  <= force_d;
      flo_q    <= flo_d;
      fhi_q    <= fhi_d;
`endif
    end
  end

  assign mutant = work_q;
  assign seg_lo = seg_lo_q;
  assign seg_hi = seg_hi_q;

endmodule

// File: tb/tb_inversion_unit.sv
// Scoreboard bench for inversion_unit: seeds chosen so the segment bounds are known by hand.
module tb_inversion_unit;

  localparam int N  = 15;
  localparam int W  = 10;
  localparam int MS = 8;
  localparam int CW = N * W;

  logic          clk = 1'b0;
  logic          rst;
  logic          seed_we;
  logic [15:0]   prg_seed;
  logic          parent_valid;
  logic          parent_ready;
  logic [CW-1:0] parent;
  logic          mutant_valid;
  logic          mutant_ready;
  logic [CW-1:0] mutant;
  logic [7:0]    seg_lo;
  logic [7:0]    seg_hi;
`ifdef INVERSION_FORCE_EN
  logic          force_en;
  logic [7:0]    force_lo;
  logic [7:0]    force_hi;
`endif

  inversion_unit #(
    .N_GENES  (N),
    .GENE_W   (W),
    .MAX_SPAN (MS),
    .SEED     (16'hACE1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .seed_we      (seed_we),
    .prg_seed     (prg_seed),
`ifdef INVERSION_FORCE_EN
    .force_en     (force_en),
    .force_lo     (force_lo),
    .force_hi     (force_hi),
`endif
    .parent_valid (parent_valid),
    .parent_ready (parent_ready),
    .parent       (parent),
    .mutant_valid (mutant_valid),
    .mutant_ready (mutant_ready),
    .mutant       (mutant),
    .seg_lo       (seg_lo),
    .seg_hi       (seg_hi)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;
  int handoffs = 0;

  typedef struct {
    logic [CW-1:0] mut;
    logic [7:0]    lo;
    logic [7:0]    hi;
    int            due;
  } exp_t;

  exp_t exp_q[$];

  task automatic chk(input string name, input logic [CW-1:0] got, input logic [CW-1:0] exp_v);
    checks++;
    if (got !== exp_v) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", name, got, exp_v, $time);
    end
  endtask

  function automatic logic [CW-1:0] make_parent(input int mode);
    logic [CW-1:0] p;
    p = '0;
    for (int i = 0; i < N; i++) begin
      if (mode == 0) p[i*W +: W] = W'(i);
      else           p[i*W +: W] = W'((i * 37 + 5 + mode * 211) % 1024);
    end
    return p;
  endfunction

  // Reference: gene at position i comes from the mirror position lo+hi-i.
  function automatic logic [CW-1:0] reverse_seg(input logic [CW-1:0] par, input int lo, input int hi);
    logic [CW-1:0] r;
    r = par;
    for (int i = lo; i <= hi; i++) r[i*W +: W] = par[(lo + hi - i)*W +: W];
    return r;
  endfunction

  task automatic send(input logic [15:0] seed, input logic [CW-1:0] par, input int lo, input int hi);
    int   n;
    exp_t e;
    @(negedge clk);
    parent       = par;
    parent_valid = 1'b1;
    seed_we      = 1'b1;
    prg_seed     = seed;
    n = 0;
    while (!parent_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!parent_ready) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout seed=%h parent_ready=%b", seed, parent_ready);
      parent_valid = 1'b0;
      seed_we      = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    parent_valid = 1'b0;
    seed_we      = 1'b0;
    e.mut = reverse_seg(par, lo, hi);
    e.lo  = 8'(lo);
    e.hi  = 8'(hi);
    e.due = cyc + 1 + (hi - lo + 1) / 2;
    exp_q.push_back(e);
  endtask

  logic          in_done = 1'b0;
  exp_t          cur;
  logic [CW-1:0] hold_m;
  logic [7:0]    hold_lo, hold_hi;

  always @(negedge clk) begin
    if (rst) begin
      in_done = 1'b0;
    end else if (mutant_valid) begin
      if (!in_done) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_mutant got=%0h expected none", mutant);
        end else begin
          cur = exp_q.pop_front();
          chk("mutant", mutant, cur.mut);
          chk("seg_lo", CW'(seg_lo), CW'(cur.lo));
          chk("seg_hi", CW'(seg_hi), CW'(cur.hi));
          chk("latency_cycle", CW'(cyc), CW'(cur.due));
        end
        hold_m  = mutant;
        hold_lo = seg_lo;
        hold_hi = seg_hi;
        in_done = 1'b1;
      end else begin
        chk("hold_mutant", mutant, hold_m);
        chk("hold_seg", CW'({seg_hi, seg_lo}), CW'({hold_hi, hold_lo}));
      end
      chk("parent_ready_in_done", CW'(parent_ready), CW'(1'b0));
      if (mutant_ready) begin
        in_done = 1'b0;
        handoffs++;
      end
    end
  end

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || in_done) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout pending=%0d required=0", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_parent_ready"}, CW'(parent_ready), CW'(1'b1));
    chk({tag, "_mutant_valid"}, CW'(mutant_valid), CW'(1'b0));
    chk({tag, "_mutant"}, mutant, '0);
    chk({tag, "_seg"}, CW'({seg_hi, seg_lo}), CW'(16'h0000));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [CW-1:0] p0, p1, p2;
    int            h0, n;
    p0 = make_parent(0);
    p1 = make_parent(1);
    p2 = make_parent(2);

    rst          = 1'b1;
    seed_we      = 1'b0;
    prg_seed     = 16'h0000;
    parent_valid = 1'b0;
    parent       = '0;
    mutant_ready = 1'b1;
`ifdef INVERSION_FORCE_EN
    force_en     = 1'b0;
    force_lo     = 8'd0;
    force_hi     = 8'd0;
`endif

    repeat (3) @(negedge clk);
    chk("lfsr_reset", CW'(dut.u_lfsr.lfsr_q), CW'(16'hACE1));
    rst = 1'b0;
    @(negedge clk);
    chk("lfsr_first_step", CW'(dut.u_lfsr.lfsr_q), CW'(16'hE270));
    repeat (4) @(negedge clk);
    check_reset_outputs("idle");

    send(16'h2367, p0, 2, 6);
    drain();
    send(16'h9A9A, p1, 9, 9);
    send(16'h00FF, p0, 0, 7);
    send(16'hFF00, p1, 0, 7);
    send(16'h12CD, p0, 1, 8);
    send(16'h239A, p1, 2, 9);
    send(16'h5510, p2, 0, 4);
    drain();

    mutant_ready = 1'b0;
    send(16'h5510, p1, 0, 4);
    n = 0;
    while (!mutant_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("hold_reached_done", CW'(mutant_valid), CW'(1'b1));
    repeat (10) @(negedge clk);
    @(posedge clk);
    #1;
    h0 = handoffs;
    mutant_ready = 1'b1;
    @(posedge clk);
    #2;
    chk("single_handoff", CW'(handoffs), CW'(h0 + 1));
    chk("after_handoff_valid", CW'(mutant_valid), CW'(1'b0));
    chk("after_handoff_ready", CW'(parent_ready), CW'(1'b1));
    repeat (3) @(negedge clk);
    chk("no_extra_handoff", CW'(handoffs), CW'(h0 + 1));

    send(16'h00FF, p2, 0, 7);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("abort_busy", CW'(parent_ready), CW'(1'b0));
    rst = 1'b1;
    @(posedge clk);
    #1;
    exp_q.delete();
    check_reset_outputs("abort");
    chk("abort_lfsr", CW'(dut.u_lfsr.lfsr_q), CW'(16'hACE1));
    @(negedge clk);
    rst = 1'b0;

    send(16'h0000, p1, 10, 13);
    drain();
    send(16'h0000, p1, 10, 13);
    drain();

`ifdef INVERSION_FORCE_EN
    force_en = 1'b1;
    force_lo = 8'd6;
    force_hi = 8'd2;
    send(16'h9A9A, p0, 2, 6);
    force_lo = 8'd3;
    force_hi = 8'd200;
    send(16'h9A9A, p1, 3, 10);
    force_en = 1'b0;
    drain();
`endif

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/inversion_unit.md
# inversion_unit

Parametrised inversion-mutation engine for the genetic-algorithm datapath. Accepts one parent chromosome of N_GENES genes, draws two gene indices from an internal LFSR, and reverses the gene order between them inclusive, one swap per cycle. Returns the mutant over a valid/ready handshake. Sits between the selection/crossover stage and the fitness evaluator, and supersedes the fixed 150-bit combinational inverter.

## Interface
- N_GENES, 15, genes per chromosome (2..255)
- GENE_W, 10, bits per gene
- MAX_SPAN, 15, maximum inverted segment length in genes (2..N_GENES)
- SEED, 16'hACE1, LFSR reset value (nonzero)
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous active-high reset
- seed_we  in  1  load prg_seed into LFSR this cycle
- prg_seed  in  16  LFSR seed; 0 is replaced by 16'hACE1
- parent_valid  in  1  parent present
- parent_ready  out  1  engine accepts parent
- parent  in  N_GENES*GENE_W  gene i = bits [i*GENE_W +: GENE_W]
- mutant_valid  out  1  result present
- mutant_ready  in  1  downstream accepts result
- mutant  out  N_GENES*GENE_W  result chromosome
- seg_lo, seg_hi  out  8 each  applied segment bounds, valid with mutant_valid

## Operation
- LFSR: 16-bit Galois, taps 16'hB400, shift right; advances every cycle unless seed_we or rst.
- States: IDLE, PICK, SWAP, DONE.
- IDLE: parent_ready=1. On parent_valid: latch parent into work register, go PICK.
- PICK: a = (lfsr[15:8]*N_GENES)>>8, b = (lfsr[7:0]*N_GENES)>>8; lo=min(a,b), hi=max(a,b); if hi-lo+1 > MAX_SPAN then hi=lo+MAX_SPAN-1. Latch seg_lo/seg_hi. Go SWAP if lo<hi, else DONE.
- SWAP: exchange genes lo and hi; lo+1, hi-1; go DONE when updated lo>=hi. Swap pointers are 8-bit; no wrap possible because lo<hi is checked before each step.
- DONE: mutant_valid=1, mutant=work register. On mutant_ready: go IDLE. mutant/seg_* stable while valid and not ready.
- lo==hi: mutant equals parent bit-exact.
- seed_we while busy: loads LFSR, does not disturb the current chromosome.

## Timing
- Reset values: parent_ready=1 (IDLE), mutant_valid=0, mutant=0, seg_lo=seg_hi=0, LFSR=SEED.
- Parent accepted in cycle T, then PICK in T+1 and k=floor((hi-lo+1)/2) SWAP cycles; mutant_valid rises in cycle T+2+k.
- Worst case latency 2+floor(MAX_SPAN/2) cycles; one chromosome in flight; throughput one per latency+1 cycles with mutant_ready held high.
- parent_ready=0 in PICK, SWAP and DONE. There is no accept in the same cycle as the mutant handoff.
- rst at any cycle aborts: next cycle is IDLE with reset values; no partial mutant_valid.

## Configuration
- INVERSION_FORCE_EN defined: adds inputs force_en (1), force_lo (8), force_hi (8).
  - If force_en is high in the accept cycle, PICK uses lo=min(force_lo,force_hi) and hi=max(...) instead of the LFSR values.
  - Indices at or above N_GENES clamp to N_GENES-1; the MAX_SPAN clamp still applies.
- Undefined: ports absent; indices always come from the LFSR.

## Structure
- Package inversion_pkg: state enum, LFSR_TAPS=16'hB400, DEFAULT_SEED=16'hACE1, 8-bit index typedef.
- Sub-module ga_lfsr: 16-bit LFSR with seed load and zero-seed substitution, reusable by the crossover block.
- Top holds FSM, work register, swap pointers and index scaling.

## Test plan
- Reset then idle 5 cycles: parent_ready=1, mutant_valid=0, mutant=0, LFSR=16'hACE1.
- FORCE, gene i = i, lo=2 hi=6, accept at T: mutant genes 0,1,6,5,4,3,2,7..14; mutant_valid at T+4; seg_lo=2, seg_hi=6.
- FORCE lo=hi=9: mutant==parent, mutant_valid at T+2.
- MAX_SPAN=4, FORCE lo=1 hi=12: hi clamps to 4; genes 0,4,3,2,1,5..14; seg_hi=4.
- mutant_ready low 10 cycles in DONE: mutant, seg_* stable; parent_ready=0; single handoff on release.
- rst asserted in second SWAP cycle: next cycle IDLE with reset values. Then seed_we prg_seed=0 twice with identical parents: same seg_lo/seg_hi both runs.
